// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for the shared FIFO.
// Bounded bursts; each word tagged with its requester index.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 2,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_data,
  output logic [TAG_WIDTH-1:0]            grant_id,
  output logic                            busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [TAG_WIDTH-1:0]  rr_ptr;
  logic [TAG_WIDTH-1:0]  owner;
  logic [TAG_WIDTH-1:0]  pick;
  logic [TAG_WIDTH-1:0]  next_ptr;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  any_valid;
  logic                  own_valid;
  logic                  transfer;
  logic                  last_beat;
  logic                  release_now;

  // Pick the valid requester closest to rr_ptr in rotation order.
  always_comb begin
    int best;
    int d;
    best = NUM_REQ;
    d    = 0;
    pick = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      d = k - int'(rr_ptr);
      if (d < 0) d = d + NUM_REQ;
      if (req_valid[k] && d < best) begin
        best = d;
        pick = TAG_WIDTH'(k);
      end
    end
  end

  assign any_valid = |req_valid;

  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == TAG_WIDTH'(k)) begin
        own_valid = req_valid[k];
        own_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy = (state == BURST);

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = busy && !fifo_full
                     && (owner == TAG_WIDTH'(k));
    end
  end

  assign transfer    = busy && own_valid && !fifo_full;
  assign last_beat   = (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));
  assign release_now = !own_valid || (transfer && last_beat);
  assign next_ptr    = (owner == TAG_WIDTH'(NUM_REQ - 1))
                       ? '0 : owner + 1'b1;

  assign fifo_wr_en = transfer;
  assign fifo_data  = busy ? {owner, own_data} : '0;
  assign grant_id   = owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (transfer) beat_cnt <= beat_cnt + 1'b1;
          if (release_now) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter.
// Scoreboard queue holds expected {tag, data} words.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [TW+DW-1:0] fifo_data;
  logic [TW-1:0]   grant_id;
  logic            busy;

  logic [DW-1:0] base  [N];
  logic [DW-1:0] taken [N];
  logic [TW+DW-1:0] sb [$];

  int vectors;
  int miscompares;

  fifo_write_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .MAX_BURST(4), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = base[i] + taken[i];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  // Output monitor: compare each write, then advance producers.
  initial for (int i = 0; i < N; i++) taken[i] = '0;
  always @(negedge clk) begin
    logic [TW+DW-1:0] e;
    if (fifo_wr_en) begin
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      chk("fifo_data", 32'(fifo_data), 32'(e));
      chk("wr_while_full", 32'(fifo_full), 0);
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i])
          taken[i] <= taken[i] + 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic setbase(input int i, input logic [DW-1:0] v);
    base[i] = v - taken[i];
  endtask

  task automatic push(input int t, input int d);
    sb.push_back({TW'(t), DW'(d)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    smp();
    chk("rst_busy", 32'(busy), 0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic bcyc(input string tag, input logic b,
                      input logic w, input int g);
    smp();
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_wr"}, 32'(fifo_wr_en), 32'(w));
    if (b) chk({tag, "_gid"}, 32'(grant_id), 32'(g));
    cyc();
  endtask

  initial begin
    #200000;
    $error("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int pat [10];
    pat = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) base[i] = '0;
    #1;
    chk("rst_wr", 32'(fifo_wr_en), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    cyc();
    rst = 1'b0;

    // 1: idle after reset
    for (int k = 0; k < 10; k++) begin
      smp();
      chk("idle_wr", 32'(fifo_wr_en), 0);
      chk("idle_rdy", 32'(req_ready), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_gid", 32'(grant_id), 0);
      cyc();
    end

    // 2: single requester, burst of 4 with bubble
    do_reset();
    setbase(2, 8'h10);
    for (int d = 0; d < 8; d++) push(2, 8'h10 + d);
    req_valid = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk("single_wr", 32'(fifo_wr_en), 32'(pat[k]));
      if (pat[k] != 0)
        chk("single_gid", 32'(grant_id), 2);
      cyc();
    end
    req_valid = '0;

    // 3: round-robin across all four
    do_reset();
    for (int i = 0; i < N; i++) setbase(i, 8'(i * 64));
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 4; b++)
        push(g % 4, (g % 4) * 64 + (g / 4) * 4 + b);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      bcyc("rr_arb", 1'b0, 1'b0, 0);
      for (int b = 0; b < 4; b++)
        bcyc("rr_beat", 1'b1, 1'b1, g % 4);
    end
    req_valid = '0;

    // 4: full stall mid-burst
    do_reset();
    setbase(1, 8'h20);
    for (int d = 0; d < 4; d++) push(1, 8'h20 + d);
    req_valid = 4'b0010;
    bcyc("stall_arb", 1'b0, 1'b0, 0);
    bcyc("stall_b0", 1'b1, 1'b1, 1);
    bcyc("stall_b1", 1'b1, 1'b1, 1);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("stall_rdy", 32'(req_ready), 0);
      cyc();
    end
    fifo_full = 1'b0;
    bcyc("stall_b2", 1'b1, 1'b1, 1);
    bcyc("stall_b3", 1'b1, 1'b1, 1);
    req_valid = '0;
    bcyc("stall_end", 1'b0, 1'b0, 0);

    // 5: early release, full during arbitration
    do_reset();
    setbase(3, 8'hD0);
    setbase(0, 8'h30);
    push(3, 8'hD0);
    for (int d = 0; d < 4; d++) push(0, 8'h30 + d);
    req_valid = 4'b1000;
    fifo_full = 1'b1;
    bcyc("early_arb", 1'b0, 1'b0, 0);
    bcyc("early_full", 1'b1, 1'b0, 3);
    fifo_full = 1'b0;
    bcyc("early_b0", 1'b1, 1'b1, 3);
    req_valid = 4'b0001;
    bcyc("early_rel", 1'b1, 1'b0, 3);
    bcyc("early_idle", 1'b0, 1'b0, 0);
    for (int b = 0; b < 4; b++)
      bcyc("early_wrap", 1'b1, 1'b1, 0);
    req_valid = '0;
    bcyc("early_end", 1'b0, 1'b0, 0);

    // 6: asynchronous reset mid-burst
    do_reset();
    setbase(2, 8'h50);
    push(2, 8'h50);
    req_valid = 4'b0100;
    bcyc("arst_arb", 1'b0, 1'b0, 0);
    bcyc("arst_b0", 1'b1, 1'b1, 2);
    #2;
    chk("arst_pre_wr", 32'(fifo_wr_en), 1);
    rst = 1'b1;
    #1;
    chk("arst_wr", 32'(fifo_wr_en), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy", 32'(req_ready), 0);
    req_valid = 4'b1111;
    setbase(0, 8'h60);
    push(0, 8'h60);
    smp();
    cyc();
    rst = 1'b0;
    bcyc("arst_arb2", 1'b0, 1'b0, 0);
    bcyc("arst_g0", 1'b1, 1'b1, 0);
    req_valid = '0;
    bcyc("arst_rel", 1'b1, 1'b0, 0);
    bcyc("arst_end", 1'b0, 1'b0, 0);

    cyc();
    cyc();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
